spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: FRAME_WIDTH, 10, receive frame length in bits (command pair + 8 payload bits).
REQ-002 Parameter: TX_WAIT_MAX, 15, maximum cycles spent waiting for tx_valid before a read is abandoned.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: SS_n  input  1  active-low slave select; low frames a transaction.
REQ-006 Port: MOSI  input  1  serial data in, MSB first, sampled every clk while selected.
REQ-007 Port: MISO  output  1  serial read data out, MSB first.
REQ-008 Port: rx_data  output  10  parallel frame to RAM; bits [9:8] are the command.
REQ-009 Port: rx_valid  output  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-010 Port: tx_data  input  8  read data from RAM.
REQ-011 Port: tx_valid  input  1  qualifies tx_data.
REQ-012 Port: frame_err  output  1  sticky command-mismatch flag; see Configuration.

Function
REQ-013 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-014 IDLE: SS_n=0 -> CHK_CMD; otherwise stay.
REQ-015 CHK_CMD: the MOSI bit sampled here becomes rx_data[9]; 0 -> WRITE; 1 with rd_addr_seen=0 -> READ_ADD; 1 with rd_addr_seen=1 -> READ_DATA.
REQ-016 WRITE, READ_ADD and READ_DATA SHALL shift in 9 further bits, one per cycle, MSB first, filling rx_data[8:0].
REQ-017 rx_valid SHALL assert for exactly one cycle, the cycle after the 10th bit is sampled; rx_data SHALL be held stable from that cycle until the next frame starts.
REQ-018 rd_addr_seen SHALL set when a READ_ADD frame completes, clear when a READ_DATA frame completes, and be unchanged by WRITE frames.
REQ-019 WRITE and READ_ADD: after rx_valid, the FSM SHALL wait for SS_n=1, then go to IDLE.
REQ-020 READ_DATA: after rx_valid, the first cycle with tx_valid=1 SHALL load tx_data into the shift register; MISO SHALL drive bits 7..0 on the following 8 cycles.
REQ-021 If tx_valid is not seen within TX_WAIT_MAX cycles of rx_valid, the FSM SHALL go to IDLE without shifting, and rd_addr_seen SHALL still clear.
REQ-022 MISO SHALL be 0 whenever not shifting; tx_valid SHALL be ignored outside the READ_DATA wait window.
REQ-023 SS_n=1 in any non-IDLE state SHALL abort to IDLE on the next edge; a partial frame SHALL produce no rx_valid, leave rd_addr_seen unchanged and stop MISO shifting immediately.
REQ-024 SS_n=1 in the same cycle as the 10th bit sample SHALL abort: the frame is discarded.
REQ-025 A new frame SHALL require at least one IDLE cycle, i.e. SS_n high between frames.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, rd_addr_seen=0, bit counter=0, rx_data=0, rx_valid=0, MISO=0 and frame_err=0.
REQ-027 Reset SHALL take priority over all other inputs, including mid-frame and mid-shift.

Configuration
REQ-028 Macro: SPI_SLAVE_CMD_CHECK_EN.
REQ-029 When defined: a completed frame whose rx_data[9:8] does not match the state SHALL be dropped, with no rx_valid and no rd_addr_seen change, and frame_err SHALL set until reset. Expected values: WRITE = 00 or 01, READ_ADD = 10, READ_DATA = 11.
REQ-030 When undefined: all completed frames SHALL be forwarded unchanged and frame_err SHALL be tied to 0.

Verification
REQ-031 Write address: SS_n low, MOSI 0,0,0xA5 (10 bits) -> rx_data=10'h0A5, rx_valid high for 1 cycle, 1 cycle after the last bit.
REQ-032 Read sequence: frame 10,0x3C, then frame 11,0x00, with tx_valid and tx_data=0x96 2 cycles later -> MISO=1,0,0,1,0,1,1,0 on the next 8 cycles; rd_addr_seen ends at 0.
REQ-033 Abort: SS_n high after 6 bits -> no rx_valid, state IDLE next cycle; the next full frame decodes correctly.
REQ-034 Timeout: READ_DATA frame with tx_valid never asserted -> IDLE after 15 cycles, MISO stays 0.
REQ-035 Reset mid-shift: rst=1 during the 4th MISO bit -> MISO=0 and state IDLE next cycle.
REQ-036 With SPI_SLAVE_CMD_CHECK_EN: READ_ADD frame carrying 11,0x12 -> no rx_valid, frame_err=1 and held until rst.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave front end for a RAM: 10-bit command+payload frames in on MOSI, 8-bit read data out on MISO.
// Optional build macro SPI_SLAVE_CMD_CHECK_EN drops frames whose command bits disagree with the decoded state.
module spi_slave #(
  parameter int FRAME_WIDTH = 10,
  parameter int TX_WAIT_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SS_n,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic [FRAME_WIDTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   frame_err
);
  localparam int CNT_W  = $clog2(FRAME_WIDTH);
  localparam int WAIT_W = $clog2(TX_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FRAME_WIDTH - 2);
  localparam logic [CNT_W-1:0]  SHIFT_LAST = CNT_W'(7);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TX_WAIT_MAX - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  // Sub-phase of the three data states: receiving, waiting for RAM, shifting MISO, holding for SS_n.
  typedef enum logic [1:0] {PH_RX, PH_WAIT, PH_SHIFT, PH_HOLD} phase_t;

  state_t                 r_state, w_state_nxt;
  phase_t                 r_phase, w_phase_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [WAIT_W-1:0]      r_wait;
  logic [FRAME_WIDTH-2:0] r_sr;
  logic [FRAME_WIDTH-1:0] r_rx_data, w_frame;
  logic [7:0]             r_tx;
  logic                   r_rx_valid, r_miso, r_rd_seen, r_ss_q;
  logic                   w_data_st, w_last, w_cmd_ok, w_accept, w_load, w_miso_nxt;

  assign w_data_st = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
  assign w_frame   = {r_sr, MOSI};
  assign w_last    = w_data_st && (r_phase == PH_RX) && (r_cnt == CNT_LAST);

`ifdef SPI_SLAVE_CMD_CHECK_EN
  logic r_ferr, w_drop;

  always_comb begin
    w_cmd_ok = 1'b1;
    if (r_state == READ_ADD)  w_cmd_ok = ~w_frame[FRAME_WIDTH-2];
    if (r_state == READ_DATA) w_cmd_ok =  w_frame[FRAME_WIDTH-2];
  end

  assign w_drop = w_last && !SS_n && !w_cmd_ok;

  always_ff @(posedge clk) begin
    if (rst)         r_ferr <= 1'b0;
    else if (w_drop) r_ferr <= 1'b1;
  end

  assign frame_err = r_ferr;
`else
  assign w_cmd_ok  = 1'b1;
  assign frame_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    if (r_state != IDLE && SS_n) begin
      w_state_nxt = IDLE;
      w_phase_nxt = PH_RX;
    end else begin
      case (r_state)
        // r_ss_q demands a high SS_n since the last frame, so a timed-out read cannot re-trigger.
        IDLE: if (!SS_n && r_ss_q) w_state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)          w_state_nxt = WRITE;
          else if (r_rd_seen) w_state_nxt = READ_DATA;
          else                w_state_nxt = READ_ADD;
        end
        default: begin
          case (r_phase)
            PH_RX: begin
              if (w_last) begin
                w_accept    = w_cmd_ok;
                w_phase_nxt = (w_cmd_ok && r_state == READ_DATA) ? PH_WAIT : PH_HOLD;
              end
            end
            PH_WAIT: begin
              if (tx_valid) begin
                w_load      = 1'b1;
                w_phase_nxt = PH_SHIFT;
              end else if (r_wait == WAIT_LAST) begin
                w_state_nxt = IDLE;
                w_phase_nxt = PH_RX;
              end
            end
            PH_SHIFT: begin
              if (r_cnt == SHIFT_LAST) begin
                w_state_nxt = IDLE;
                w_phase_nxt = PH_RX;
              end
            end
            default: ;
          endcase
        end
      endcase
    end
    w_miso_nxt = 1'b0;
    if (w_load)                                            w_miso_nxt = tx_data[7];
    else if (r_phase == PH_SHIFT && w_state_nxt != IDLE)   w_miso_nxt = r_tx[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_phase    <= PH_RX;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_sr       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx       <= '0;
      r_miso     <= 1'b0;
      r_rd_seen  <= 1'b0;
      r_ss_q     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_ss_q     <= SS_n;
      r_rx_valid <= w_accept;
      r_miso     <= w_miso_nxt;

      if (r_state == CHK_CMD) begin
        r_sr  <= {{(FRAME_WIDTH-2){1'b0}}, MOSI};
        r_cnt <= '0;
      end else if (w_data_st && r_phase == PH_RX) begin
        r_sr  <= w_frame[FRAME_WIDTH-2:0];
        r_cnt <= r_cnt + 1'b1;
      end else if (w_load) begin
        r_cnt <= '0;
      end else if (r_phase == PH_SHIFT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_load)                   r_tx <= {tx_data[6:0], 1'b0};
      else if (r_phase == PH_SHIFT) r_tx <= {r_tx[6:0], 1'b0};

      if (w_accept)                 r_wait <= '0;
      else if (r_phase == PH_WAIT)  r_wait <= r_wait + 1'b1;

      if (w_accept) r_rx_data <= w_frame;

      if (w_accept && r_state == READ_ADD)       r_rd_seen <= 1'b1;
      else if (w_accept && r_state == READ_DATA) r_rd_seen <= 1'b0;
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign MISO     = r_miso;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a transaction-level model schedules per-cycle expectations
// (rx_valid, MISO, rx_data, frame_err) that one negedge process compares against the DUT.
module tb_spi_slave;
  localparam int FW   = 10;
  localparam int TW   = 15;
  localparam int MAXC = 1024;

  logic       clk = 1'b0, rst = 1'b1, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       MISO, rx_valid, frame_err;
  logic [9:0] rx_data;

  spi_slave #(.FRAME_WIDTH(FW), .TX_WAIT_MAX(TW)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs indexed by the cycle following each rising edge.
  bit         e_vld  [MAXC];
  bit         e_miso [MAXC];
  bit         u_data [MAXC];
  logic [9:0] v_data [MAXC];
  bit         u_ferr [MAXC];
  bit         v_ferr [MAXC];

  int         n_cmp = 0, n_bad = 0;
  bit         run = 1'b1;
  logic [9:0] m_data = '0;
  bit         m_ferr = 1'b0;
  bit         m_seen = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, want);
    end
  endtask

  task automatic chkw(input string nm, input logic [9:0] act, input logic [9:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (run && cyc >= 1 && cyc < MAXC) begin
        if (u_data[cyc]) m_data = v_data[cyc];
        if (u_ferr[cyc]) m_ferr = v_ferr[cyc];
        chk1("rx_valid", rx_valid, e_vld[cyc]);
        chk1("miso", MISO, e_miso[cyc]);
        chkw("rx_data", rx_data, m_data);
        chk1("frame_err", frame_err, m_ferr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends nbits bits normally; if nbits < 10 the next bit goes out with SS_n high (abort).
  task automatic frame(input logic [9:0] f, input int nbits, output bit rd_go);
    int kind;
    bit ok;
    rd_go = 1'b0;
    kind  = f[9] ? (m_seen ? 2 : 1) : 0;
    SS_n  = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      MOSI = f[9-i];
      if (i == nbits) SS_n = 1'b1;
      tick();
      if (i == nbits) break;
    end
    MOSI = 1'b0;
    if (nbits >= 10) begin
      ok = 1'b1;
`ifdef SPI_SLAVE_CMD_CHECK_EN
      if (kind == 1 && f[8])  ok = 1'b0;
      if (kind == 2 && !f[8]) ok = 1'b0;
`endif
      if (ok) begin
        e_vld[cyc]  = 1'b1;
        u_data[cyc] = 1'b1;
        v_data[cyc] = f;
        if (kind == 1) m_seen = 1'b1;
        if (kind == 2) m_seen = 1'b0;
        rd_go = (kind == 2);
      end else begin
        u_ferr[cyc] = 1'b1;
        v_ferr[cyc] = 1'b1;
      end
    end
  endtask

  // Entered in the rx_valid cycle; tx_valid goes high d cycles later for one cycle.
  task automatic tx_wait(input int d, input logic [7:0] dat, input bit rd_go, output int l);
    for (int k = 0; k < d; k++) tick();
    tx_valid = 1'b1;
    tx_data  = dat;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    l = cyc;
    if (rd_go && d < TW)
      for (int j = 0; j < 8; j++) e_miso[cyc+j] = dat[7-j];
  endtask

  task automatic release_ss();
    SS_n = 1'b1;
    tick();
  endtask

  task automatic clr_miso(input int from);
    for (int k = from; k < from + 8; k++) e_miso[k] = 1'b0;
  endtask

  initial begin
    bit         g;
    int         l;
    logic [7:0] pat;

    tick();
    tick();
    chkw("rst_rx_data", rx_data, 10'h000);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_miso", MISO, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    tick();
    tick();

    // Write frames, both write command encodings.
    frame(10'h0A5, 10, g);
    chkw("wr_lit_data", rx_data, 10'h0A5);
    chk1("wr_lit_vld", rx_valid, 1'b1);
    release_ss();
    chk1("wr_vld_one_cycle", rx_valid, 1'b0);
    chkw("wr_data_hold", rx_data, 10'h0A5);
    frame(10'h15A, 10, g);
    release_ss();

    // Read address then read data, RAM answers 2 cycles after rx_valid.
    frame(10'h23C, 10, g);
    release_ss();
    frame(10'h300, 10, g);
    tx_wait(2, 8'h96, g, l);
    pat = 8'h96;
    for (int j = 0; j < 8; j++) begin
      chk1("rd_miso_lit", MISO, pat[7-j]);
      tick();
    end
    chk1("rd_miso_end", MISO, 1'b0);
    release_ss();

    // rd_addr_seen cleared: this 1x frame is an address, so tx_valid is ignored.
    frame(10'h2C3, 10, g);
    tx_wait(1, 8'hFF, g, l);
    chk1("rdadd_no_miso", MISO, 1'b0);
    tick();
    release_ss();

    // Abort together with the 10th bit, then a read that loads on the last wait cycle.
    frame(10'h3AA, 9, g);
    chk1("abort10_no_vld", rx_valid, 1'b0);
    frame(10'h355, 10, g);
    tx_wait(14, 8'hC3, g, l);
    chk1("late_load_msb", MISO, 1'b1);
    for (int j = 0; j < 9; j++) tick();
    release_ss();

    // Abort after 6 bits, next frame must decode cleanly.
    frame(10'h0FF, 6, g);
    chk1("abort6_no_vld", rx_valid, 1'b0);
    frame(10'h066, 10, g);
    chkw("after_abort_data", rx_data, 10'h066);
    release_ss();

    // Timeout: tx_valid arrives one cycle too late and must be ignored.
    frame(10'h211, 10, g);
    release_ss();
    frame(10'h3EE, 10, g);
    tx_wait(15, 8'hA5, g, l);
    chk1("timeout_miso", MISO, 1'b0);
    for (int j = 0; j < 3; j++) tick();
    release_ss();
    frame(10'h244, 10, g);
    tx_wait(0, 8'hFF, g, l);
    for (int j = 0; j < 3; j++) tick();
    release_ss();

    // Bring rd_addr_seen back to 0, then send an address frame with command 11.
    frame(10'h381, 10, g);
    tx_wait(0, 8'h81, g, l);
    for (int j = 0; j < 8; j++) tick();
    release_ss();
    frame(10'h312, 10, g);
`ifdef SPI_SLAVE_CMD_CHECK_EN
    chk1("cmd_err_no_vld", rx_valid, 1'b0);
    chk1("cmd_err_flag", frame_err, 1'b1);
`else
    chk1("nochk_vld", rx_valid, 1'b1);
    chk1("nochk_flag", frame_err, 1'b0);
`endif
    release_ss();
    frame(10'h0C3, 10, g);
    release_ss();

    // Reset during the 4th MISO bit.
    if (!m_seen) begin
      frame(10'h201, 10, g);
      release_ss();
    end
    frame(10'h3F0, 10, g);
    tx_wait(0, 8'h5A, g, l);
    for (int j = 0; j < 3; j++) tick();
    chk1("pre_rst_bit4", MISO, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr_miso(cyc);
    u_data[cyc] = 1'b1;
    v_data[cyc] = 10'h000;
    u_ferr[cyc] = 1'b1;
    v_ferr[cyc] = 1'b0;
    m_seen = 1'b0;
    chk1("rst_mid_miso", MISO, 1'b0);
    chkw("rst_mid_data", rx_data, 10'h000);
    chk1("rst_mid_ferr", frame_err, 1'b0);
    SS_n = 1'b1;
    tick();
    tick();

    // SS_n raised mid-shift stops MISO at the next edge.
    frame(10'h2A0, 10, g);
    release_ss();
    frame(10'h3B0, 10, g);
    tx_wait(1, 8'hFF, g, l);
    tick();
    tick();
    SS_n = 1'b1;
    tick();
    clr_miso(cyc);
    chk1("ss_abort_miso", MISO, 1'b0);
    tick();

    frame(10'h0A5, 10, g);
    chkw("final_wr_data", rx_data, 10'h0A5);
    release_ss();
    tick();
    tick();

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
